// File: rtl/sq_wave_pkg.sv
// Shared types and constants for the square-wave generator (sq_wave_gen).
package sq_wave_pkg;

    typedef enum logic [1:0] {
        SQ_IDLE = 2'd0,
        SQ_HIGH = 2'd1,
        SQ_LOW  = 2'd2
    } sq_state_t;

    localparam int REF_CLK_NS       = 2;
    localparam int SQ_CNT_W_DEFAULT = 32;

endpackage

// File: rtl/sq_cfg_shadow.sv
// Configuration double buffer: accepts a shadow on/off pair and promotes it to the
// active pair on request, keeping time_period in step with the active pair.
module sq_cfg_shadow
    import sq_wave_pkg::*;
#(
    parameter int CNT_W = SQ_CNT_W_DEFAULT
) (
    input  logic             ref_clk,
    input  logic             rst,
    input  logic             cfg_valid,
    input  logic [CNT_W-1:0] cfg_on,
    input  logic [CNT_W-1:0] cfg_off,
    input  logic             promote,
    output logic             cfg_ready,
    output logic             pend,
    output logic [CNT_W-1:0] on_act,
    output logic [CNT_W-1:0] off_act,
    output logic [CNT_W-1:0] on_nxt,
    output logic [CNT_W-1:0] off_nxt,
    output logic [CNT_W+1:0] time_period
);

    localparam int TP_W = CNT_W + 2;

    logic [CNT_W-1:0] on_sh;
    logic [CNT_W-1:0] off_sh;
    logic [TP_W-1:0]  sh_period;

    // Valid/ready: a config transfers on any edge where cfg_valid && cfg_ready;
    // the slot stays full (ready low) until the shadow is promoted.
    assign cfg_ready = !pend;

    // Values the next period will use if promotion happens on this edge.
    assign on_nxt  = pend ? on_sh  : on_act;
    assign off_nxt = pend ? off_sh : off_act;

    assign sh_period = (TP_W'(on_sh) + TP_W'(off_sh)) * TP_W'(REF_CLK_NS);

    always_ff @(posedge ref_clk) begin
        if (rst) begin
            on_sh       <= '0;
            off_sh      <= '0;
            on_act      <= '0;
            off_act     <= '0;
            pend        <= 1'b0;
            time_period <= '0;
        end else if (cfg_valid && cfg_ready) begin
            on_sh  <= cfg_on;
            off_sh <= cfg_off;
            pend   <= 1'b1;
        end else if (promote && pend) begin
            on_act      <= on_sh;
            off_act     <= off_sh;
            pend        <= 1'b0;
            time_period <= sh_period;
        end
    end

endmodule

// File: rtl/sq_wave_gen.sv
// Programmable square-wave generator with period-boundary config updates.
// Optional burst mode (burst_len / burst_done) is built when SQ_WAVE_GEN_BURST_EN is defined.
module sq_wave_gen
    import sq_wave_pkg::*;
#(
    parameter int CNT_W = SQ_CNT_W_DEFAULT
) (
    input  logic             ref_clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [CNT_W-1:0] cfg_on,
    input  logic [CNT_W-1:0] cfg_off,
    output logic             sq_wave,
    output logic             period_done,
    output logic [CNT_W+1:0] time_period,
    output logic             busy,
`ifdef SQ_WAVE_GEN_BURST_EN
    input  logic [15:0]      burst_len,
    output logic             burst_done,
`endif
    output sq_state_t        dbg_state
);

    sq_state_t        state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             sq_nxt;
    logic             pd_nxt;
    logic             promote;
    logic             period_end;
    logic             launch;
    logic             idle_exit;
    logic [CNT_W-1:0] run_on, run_off;
    logic             pend;
    logic [CNT_W-1:0] on_act, off_act, on_nxt, off_nxt;
    logic             burst_last;
    logic             burst_hold;

    sq_cfg_shadow #(.CNT_W(CNT_W)) u_shadow (
        .ref_clk     (ref_clk),
        .rst         (rst),
        .cfg_valid   (cfg_valid),
        .cfg_on      (cfg_on),
        .cfg_off     (cfg_off),
        .promote     (promote),
        .cfg_ready   (cfg_ready),
        .pend        (pend),
        .on_act      (on_act),
        .off_act     (off_act),
        .on_nxt      (on_nxt),
        .off_nxt     (off_nxt),
        .time_period (time_period)
    );

    assign busy      = (state != SQ_IDLE);
    assign dbg_state = state;

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        sq_nxt     = sq_wave;
        pd_nxt     = 1'b0;
        promote    = 1'b0;
        period_end = 1'b0;
        launch     = 1'b0;
        idle_exit  = 1'b0;
        run_on     = on_act;
        run_off    = off_act;

        case (state)
            SQ_IDLE: begin
                promote = pend;
                sq_nxt  = 1'b0;
                if (enable && !pend && !burst_hold && (on_act != '0 || off_act != '0)) begin
                    launch    = 1'b1;
                    idle_exit = 1'b1;
                end
            end
            SQ_HIGH: begin
                if (cnt == '0) begin
                    if (off_act != '0) begin
                        state_nxt = SQ_LOW;
                        cnt_nxt   = off_act - 1'b1;
                        sq_nxt    = 1'b0;
                    end else begin
                        period_end = 1'b1;
                    end
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            SQ_LOW: begin
                if (cnt == '0) period_end = 1'b1;
                else           cnt_nxt    = cnt - 1'b1;
            end
            default: begin
                state_nxt = SQ_IDLE;
                sq_nxt    = 1'b0;
            end
        endcase

        // The next period always runs on the post-promotion values.
        if (period_end) begin
            pd_nxt  = 1'b1;
            promote = pend;
            run_on  = on_nxt;
            run_off = off_nxt;
            if (!enable || burst_last || (on_nxt == '0 && off_nxt == '0)) begin
                state_nxt = SQ_IDLE;
                sq_nxt    = 1'b0;
            end else begin
                launch = 1'b1;
            end
        end

        if (launch) begin
            if (run_on != '0) begin
                state_nxt = SQ_HIGH;
                cnt_nxt   = run_on - 1'b1;
                sq_nxt    = 1'b1;
            end else begin
                state_nxt = SQ_LOW;
                cnt_nxt   = run_off - 1'b1;
                sq_nxt    = 1'b0;
            end
        end
    end

    always_ff @(posedge ref_clk) begin
        if (rst) begin
            state       <= SQ_IDLE;
            cnt         <= '0;
            sq_wave     <= 1'b0;
            period_done <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            sq_wave     <= sq_nxt;
            period_done <= pd_nxt;
        end
    end

`ifdef SQ_WAVE_GEN_BURST_EN
    logic [15:0] burst_len_lat;
    logic [15:0] burst_cnt;

    assign burst_last = (burst_len_lat != 16'd0) && (burst_cnt == burst_len_lat - 16'd1);

    // burst_hold blocks a restart until enable has been seen low after a burst.
    always_ff @(posedge ref_clk) begin
        if (rst) begin
            burst_len_lat <= 16'd0;
            burst_cnt     <= 16'd0;
            burst_hold    <= 1'b0;
            burst_done    <= 1'b0;
        end else begin
            burst_done <= period_end && burst_last;
            if (idle_exit) begin
                burst_len_lat <= burst_len;
                burst_cnt     <= 16'd0;
            end else if (period_end) begin
                burst_cnt <= burst_cnt + 16'd1;
            end
            if (period_end && burst_last) burst_hold <= 1'b1;
            else if (!enable)             burst_hold <= 1'b0;
        end
    end
`else
    assign burst_last = 1'b0;
    assign burst_hold = 1'b0;
`endif

endmodule
